// File: rtl/video_pkg.sv
// Shared video definitions: frame-reader FSM encodings, pixel word layout
// and the burst-length helper used by the framebuffer read streamer.
package video_pkg;

    typedef logic [1:0] fb_state_t;

    localparam fb_state_t ST_IDLE  = 2'd0;
    localparam fb_state_t ST_REQ   = 2'd1;
    localparam fb_state_t ST_DRAIN = 2'd2;

    // Pixel word in memory is {8'h00, R, G, B}
    localparam int PIX_B_LSB  = 0;
    localparam int PIX_G_LSB  = 8;
    localparam int PIX_R_LSB  = 16;
    localparam int PIX_COMP_W = 8;

    function automatic logic [7:0] clip_burst(input logic [31:0] remaining,
                                              input logic [7:0]  max_len);
        return (remaining >= {24'd0, max_len}) ? max_len : remaining[7:0];
    endfunction

endpackage

// File: rtl/fb_read_stream_if.sv
// Bus bundle for the framebuffer reader: Avalon-MM burst read master side
// plus the outgoing RGB pixel stream.
interface fb_read_stream_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic [7:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    logic [7:0]  r_out;
    logic [7:0]  g_out;
    logic [7:0]  b_out;
    logic        data_valid_out;
    logic        sop_out;
    logic        eop_out;
    logic        ready_in;

    // Pixel stream: a pixel moves on every clock where data_valid_out and
    // ready_in are both 1; while valid is high and ready low, the pixel,
    // sop and eop hold. Memory side: a burst is taken when avm_read is 1
    // and avm_waitrequest is 0; the request holds until then.
    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output r_out, g_out, b_out, data_valid_out, sop_out, eop_out,
        input  ready_in
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  r_out, g_out, b_out, data_valid_out, sop_out, eop_out,
        output ready_in
    );

endinterface

// File: rtl/fb_sc_fifo.sv
// Single-clock show-ahead FIFO: rd_data is the current head, level counts
// stored entries. Writes while full are dropped.
module fb_sc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = DEPTH[LW-1:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && (level_q != FULL_LVL);
        do_rd    = rd_en && (level_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        level_d  = level_q + LW'(do_wr) - LW'(do_rd);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level gates every use of the array.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/fb_read_stream.sv
// Framebuffer reader: fetches one frame with Avalon-MM burst reads, buffers
// the words in a show-ahead FIFO and streams them out as RGB pixels.
module fb_read_stream
    import video_pkg::*;
#(
    parameter int FRAME_W    = 1280,
    parameter int FRAME_H    = 720,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_frame,
    input  logic [31:0]       fb_base_addr,
    fb_read_stream_if.master  bus,
    output logic              busy,
    output fb_state_t         dbg_state
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL   = FIFO_DEPTH[LVL_W-1:0];
    localparam logic [31:0]      TOTAL_WORDS = 32'(FRAME_W * FRAME_H);
    localparam logic [31:0]      LAST_IDX    = TOTAL_WORDS - 32'd1;
    localparam logic [7:0]       MAX_BURST   = 8'(BURST_LEN);

    fb_state_t        state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             read_q, read_d;
    logic [7:0]       bc_q, bc_d;
    logic [31:0]      remaining_q, remaining_d;
    logic [LVL_W-1:0] outstanding_q, outstanding_d;
    logic [31:0]      pix_idx_q, pix_idx_d;

    logic [LVL_W-1:0] fifo_level;
    logic             fifo_empty;
    logic [31:0]      head_word;
    logic [7:0]       unused_pad;
    logic [7:0]       next_len;
    logic [LVL_W-1:0] credit;
    logic             accepted;
    logic             xfer;
    logic             last_pix;

    fb_sc_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bus.avm_readdatavalid),
        .wr_data (bus.avm_readdata),
        .rd_en   (xfer),
        .rd_data (head_word),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        next_len = clip_burst(remaining_q, MAX_BURST);
        // level + outstanding never exceeds the depth, so this cannot wrap
        credit   = DEPTH_LVL - fifo_level - outstanding_q;
        accepted = read_q && !bus.avm_waitrequest;
        xfer     = !fifo_empty && bus.ready_in;
        last_pix = (pix_idx_q == LAST_IDX);

        state_d       = state_q;
        addr_d        = addr_q;
        read_d        = read_q;
        bc_d          = bc_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q - LVL_W'(bus.avm_readdatavalid);
        pix_idx_d     = pix_idx_q;

        if (xfer) begin
            pix_idx_d = last_pix ? 32'd0 : pix_idx_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    state_d     = ST_REQ;
                    addr_d      = fb_base_addr;
                    remaining_d = TOTAL_WORDS;
                end
            end
            ST_REQ: begin
                if (accepted) begin
                    read_d        = 1'b0;
                    addr_d        = addr_q + {22'd0, bc_q, 2'b00};
                    remaining_d   = remaining_q - {24'd0, bc_q};
                    outstanding_d = outstanding_d + LVL_W'(bc_q);
                    if (remaining_q == {24'd0, bc_q}) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!read_q && (remaining_q != 32'd0) &&
                             (credit >= LVL_W'(next_len))) begin
                    read_d = 1'b1;
                    bc_d   = next_len;
                end
            end
            ST_DRAIN: begin
                if (xfer && last_pix) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            read_q        <= 1'b0;
            bc_q          <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            pix_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            read_q        <= read_d;
            bc_q          <= bc_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            pix_idx_q     <= pix_idx_d;
        end
    end

    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_burstcount = bc_q;

    // Colour is forced to zero when empty so the unreset array never leaks out
    assign bus.data_valid_out = !fifo_empty;
    assign bus.r_out   = fifo_empty ? 8'd0 : head_word[PIX_R_LSB +: PIX_COMP_W];
    assign bus.g_out   = fifo_empty ? 8'd0 : head_word[PIX_G_LSB +: PIX_COMP_W];
    assign bus.b_out   = fifo_empty ? 8'd0 : head_word[PIX_B_LSB +: PIX_COMP_W];
    assign bus.sop_out = !fifo_empty && (pix_idx_q == 32'd0);
    assign bus.eop_out = !fifo_empty && last_pix;
    assign unused_pad  = head_word[31:24];

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_read_stream.sv
// Directed bench for fb_read_stream: a 4x2 and a 3x2 instance share one
// memory model and pixel scoreboard selected by sel.
module tb_fb_read_stream;
    import video_pkg::*;

    typedef struct {
        logic [31:0] base;
        logic        sel;
        int          mode;
        int          wcyc;
        int          second_at;
        logic [31:0] second_base;
        int          npix;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] base = '0;
    logic        wait_r = 1'b0;
    logic        rdv_r = 1'b0;
    logic [31:0] rdata_r = '0;
    logic        ready_r = 1'b0;
    int          rdy_mode = 0;
    int          cyc = 0;
    int          stall_until = 0;

    int n_vec = 0;
    int n_err = 0;
    int n_pix = 0;
    int n_sop = 0;
    int n_eop = 0;
    int occ = 0;
    int outs = 0;

    logic [25:0] exp_q[$];
    logic [31:0] slave_q[$];
    logic [31:0] burst_addr[$];
    logic [7:0]  burst_cnt[$];

    logic        prev_wait = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] wait_addr = '0;
    logic [7:0]  wait_bc = '0;
    logic [25:0] stall_pix = '0;

    fb_read_stream_if bus_a ();
    fb_read_stream_if bus_b ();
    logic      busy_a, busy_b;
    fb_state_t dbg_a, dbg_b;

    assign bus_a.avm_waitrequest   = wait_r;
    assign bus_a.avm_readdata      = rdata_r;
    assign bus_a.avm_readdatavalid = rdv_r && !sel;
    assign bus_a.ready_in          = ready_r;
    assign bus_b.avm_waitrequest   = wait_r;
    assign bus_b.avm_readdata      = rdata_r;
    assign bus_b.avm_readdatavalid = rdv_r && sel;
    assign bus_b.ready_in          = ready_r;

    fb_read_stream #(.FRAME_W(4), .FRAME_H(2), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_frame  (start && !sel),
        .fb_base_addr (base),
        .bus          (bus_a.master),
        .busy         (busy_a),
        .dbg_state    (dbg_a)
    );

    fb_read_stream #(.FRAME_W(3), .FRAME_H(2), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_frame  (start && sel),
        .fb_base_addr (base),
        .bus          (bus_b.master),
        .busy         (busy_b),
        .dbg_state    (dbg_b)
    );

    logic        m_read, m_valid, m_sop, m_eop, m_busy;
    logic [31:0] m_addr;
    logic [7:0]  m_bc, m_r, m_g, m_b;
    fb_state_t   m_dbg;

    assign m_read  = sel ? bus_b.avm_read       : bus_a.avm_read;
    assign m_addr  = sel ? bus_b.avm_address    : bus_a.avm_address;
    assign m_bc    = sel ? bus_b.avm_burstcount : bus_a.avm_burstcount;
    assign m_valid = sel ? bus_b.data_valid_out : bus_a.data_valid_out;
    assign m_sop   = sel ? bus_b.sop_out        : bus_a.sop_out;
    assign m_eop   = sel ? bus_b.eop_out        : bus_a.eop_out;
    assign m_r     = sel ? bus_b.r_out          : bus_a.r_out;
    assign m_g     = sel ? bus_b.g_out          : bus_a.g_out;
    assign m_b     = sel ? bus_b.b_out          : bus_a.b_out;
    assign m_busy  = sel ? busy_b               : busy_a;
    assign m_dbg   = sel ? dbg_b                : dbg_a;

    // Clock / reset / free-running cycle count
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    // Memory contents are a function of the byte address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'h00, a[15:8], a[7:0] ^ 8'h5a, a[9:2]};
    endfunction

    function automatic logic [25:0] exp_pix(input logic [31:0] a, input logic s, input logic e);
        return {s, e, a[15:8], a[7:0] ^ 8'h5a, a[9:2]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready driver
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ready_r = 1'b1;
            1:       ready_r = 1'($urandom_range(0, 1));
            default: ready_r = (cyc >= stall_until);
        endcase
    end

    // Negedge monitor: scoreboard, hold checks, and the memory slave model
    always @(negedge clk) begin : mon
        logic [25:0] cur;
        if (!reset_n) begin
            slave_q.delete();
            rdv_r = 1'b0;
            rdata_r = '0;
            occ = 0;
            outs = 0;
            prev_wait = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cur = {m_sop, m_eop, m_r, m_g, m_b};
            if (prev_wait) check("wait_hold", {m_read, m_bc, m_addr}, {1'b1, wait_bc, wait_addr});
            prev_wait = m_read && wait_r;
            wait_addr = m_addr;
            wait_bc = m_bc;

            if (prev_stall) check("stall_hold", {m_valid, cur}, {1'b1, stall_pix});
            prev_stall = m_valid && !ready_r;
            stall_pix = cur;

            if (m_valid && ready_r) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_pixel: got pixel 0x%0h, want none", cur);
                end else begin
                    check("pixel", cur, exp_q.pop_front());
                end
                n_pix++;
                if (m_sop) n_sop++;
                if (m_eop) begin
                    n_eop++;
                    check("busy_at_eop", m_busy, 1);
                end
                occ--;
            end

            // Returned data starts the cycle after a burst is taken
            if (slave_q.size() > 0) begin
                rdata_r = mem_word(slave_q.pop_front());
                rdv_r = 1'b1;
                occ++;
                outs--;
            end else begin
                rdv_r = 1'b0;
                rdata_r = '0;
            end

            if (m_read && !wait_r) begin
                burst_addr.push_back(m_addr);
                burst_cnt.push_back(m_bc);
                for (int k = 0; k < int'(m_bc); k++) slave_q.push_back(m_addr + 32'(4 * k));
                outs += int'(m_bc);
            end
            check("credit_le_depth", (occ + outs <= 8), 1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"}, m_read, 0);
        check({tag, "_addr"}, m_addr, 0);
        check({tag, "_bc"}, m_bc, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_sop_eop"}, {m_sop, m_eop}, 0);
        check({tag, "_rgb"}, {m_r, m_g, m_b}, 0);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_state"}, m_dbg, ST_IDLE);
    endtask

    task automatic pulse_start(input logic [31:0] b);
        @(posedge clk);
        #1 start = 1'b1;
        base = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int t;
        int nb;
        int exp_cnt;
        for (int i = 0; i < v.npix; i++)
            exp_q.push_back(exp_pix(v.base + 32'(4 * i), i == 0, i == v.npix - 1));
        burst_addr.delete();
        burst_cnt.delete();
        n_pix = 0;
        n_sop = 0;
        n_eop = 0;
        rdy_mode = v.mode;
        stall_until = cyc + 25;
        pulse_start(v.base);
        @(negedge clk);
        check("busy_after_start", m_busy, 1);

        if (v.wcyc > 0) begin
            for (t = 0; t < 20; t++) begin
                @(posedge clk);
                #1;
                if (m_read) break;
            end
            check("read_seen", m_read, 1);
            wait_r = 1'b1;
            repeat (v.wcyc) @(posedge clk);
            #1 wait_r = 1'b0;
        end

        if (v.second_at >= 0) begin
            repeat (v.second_at) @(posedge clk);
            #1 start = 1'b1;
            base = v.second_base;
            @(posedge clk);
            #1 start = 1'b0;
        end

        for (t = 0; t < 400 && !(n_pix >= v.npix && !m_busy); t++) @(negedge clk);
        repeat (10) @(negedge clk);

        check("pixel_count", n_pix, v.npix);
        check("sop_count", n_sop, 1);
        check("eop_count", n_eop, 1);
        check("exp_q_empty", exp_q.size(), 0);
        check("busy_after_eop", m_busy, 0);
        check("state_idle", m_dbg, ST_IDLE);
        nb = (v.npix + 3) / 4;
        check("burst_count", burst_addr.size(), nb);
        for (int k = 0; k < nb && k < burst_addr.size(); k++) begin
            exp_cnt = (v.npix - 4 * k > 4) ? 4 : v.npix - 4 * k;
            check("burst_addr", burst_addr[k], v.base + 32'(16 * k));
            check("burst_cnt", burst_cnt[k], exp_cnt);
        end
        exp_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int t;
        vecs[0] = '{base: 32'h1000, sel: 1'b0, mode: 0, wcyc: 0, second_at: -1, second_base: 32'h0, npix: 8};
        vecs[1] = '{base: 32'h2000, sel: 1'b0, mode: 2, wcyc: 0, second_at: -1, second_base: 32'h0, npix: 8};
        vecs[2] = '{base: 32'h3000, sel: 1'b0, mode: 0, wcyc: 5, second_at: -1, second_base: 32'h0, npix: 8};
        vecs[3] = '{base: 32'h4400, sel: 1'b1, mode: 0, wcyc: 0, second_at: -1, second_base: 32'h0, npix: 6};
        vecs[4] = '{base: 32'h1000, sel: 1'b0, mode: 0, wcyc: 0, second_at: 3, second_base: 32'h9000, npix: 8};
        vecs[5] = '{base: 32'h5000, sel: 1'b0, mode: 1, wcyc: 0, second_at: -1, second_base: 32'h0, npix: 8};
        vecs[6] = '{base: 32'h6040, sel: 1'b1, mode: 1, wcyc: 0, second_at: -1, second_base: 32'h0, npix: 6};

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            run_frame(vecs[i]);
        end

        // Reset pulsed after three pixels, then a fresh frame
        sel = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_pix(32'h7000 + 32'(4 * i), i == 0, i == 7));
        n_pix = 0;
        pulse_start(32'h7000);
        for (t = 0; t < 100 && n_pix < 3; t++) @(negedge clk);
        check("pre_reset_pixels", n_pix, 3);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_frame('{base: 32'h8000, sel: 1'b0, mode: 0, wcyc: 0, second_at: -1, second_base: 32'h0, npix: 8});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_read_stream.md
FB_READ_STREAM -- requirements
Module: fb_read_stream

Interface
REQ-001 SHALL have parameter FRAME_W, default 1280, meaning active pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 720, meaning active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning maximum words per memory read burst (power of 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, meaning pixel FIFO entries (power of 2, at least 2*BURST_LEN).
REQ-005 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port start_frame, input, 1, meaning a one-cycle pulse that requests one frame readout.
REQ-008 SHALL have port fb_base_addr, input, 32, meaning the frame byte base address, latched on an accepted start_frame.
REQ-009 SHALL have port avm_address, output, 32, meaning the burst byte address.
REQ-010 SHALL have port avm_read, output, 1, meaning a read request.
REQ-011 SHALL have port avm_burstcount, output, 8, meaning the words in the current burst.
REQ-012 SHALL have port avm_waitrequest, input, 1, meaning the slave stalls the request.
REQ-013 SHALL have port avm_readdata, input, 32, meaning a pixel word {8'h00, R, G, B}.
REQ-014 SHALL have port avm_readdatavalid, input, 1, meaning avm_readdata is valid.
REQ-015 SHALL have ports r_out, g_out and b_out, each output, 8, meaning pixel colour components.
REQ-016 SHALL have port data_valid_out, output, 1, meaning a pixel is presented on the output stream.
REQ-017 SHALL have port sop_out, output, 1, meaning the first pixel of a frame.
REQ-018 SHALL have port eop_out, output, 1, meaning the last pixel of a frame.
REQ-019 SHALL have port ready_in, input, 1, meaning the downstream consumer accepts a pixel.
REQ-020 SHALL have port busy, output, 1, meaning a frame readout is in progress.

Function
REQ-021 SHALL accept start_frame only in state IDLE; start_frame in any other state is ignored with no side effect.
REQ-022 SHALL implement FSM states IDLE, REQ, DRAIN:
- IDLE -> REQ on an accepted start_frame.
- REQ -> DRAIN once the last burst is accepted.
- DRAIN -> IDLE when the eop pixel is transferred.
REQ-023 SHALL issue a burst in REQ only when (FIFO free entries - outstanding words) >= current burst length; otherwise avm_read SHALL be held 0.
REQ-024 SHALL use burst length = min(BURST_LEN, remaining words), where total words = FRAME_W*FRAME_H.
REQ-025 SHALL keep avm_read, avm_address and avm_burstcount stable while avm_waitrequest=1.
REQ-026 SHALL consider a burst accepted when avm_read=1 and avm_waitrequest=0.
REQ-027 SHALL advance the address by 4*burst length on each accepted burst.
REQ-028 SHALL write every avm_readdatavalid word into the FIFO and decrement the outstanding count by 1 per word; the FIFO SHALL never overflow.
REQ-029 SHALL drive data_valid_out=1 whenever the FIFO is non-empty; a transfer occurs when data_valid_out=1 and ready_in=1.
REQ-030 SHALL present the FIFO head combinationally (zero-latency show-ahead) and keep r/g/b stable while data_valid_out=1 and ready_in=0.
REQ-031 SHALL assert sop_out on pixel index 0 of the frame and eop_out on pixel index FRAME_W*FRAME_H-1, both only while data_valid_out=1.
REQ-032 SHALL reset the pixel index to 0 after the eop transfer.
REQ-033 SHALL size outstanding-count and FIFO-level arithmetic as clog2(FIFO_DEPTH)+1 bits with no wrap.
REQ-034 SHALL drive busy=1 in REQ and DRAIN.
REQ-035 SHALL, when FRAME_W*FRAME_H is not a multiple of BURST_LEN, use a short final burst.

Reset
REQ-036 SHALL, on reset_n=0, immediately set the FSM to IDLE, clear the FIFO, pointers, outstanding count and pixel index, and drive avm_read=0, avm_address=0, avm_burstcount=0, data_valid_out=0, sop_out=0, eop_out=0, r/g/b=0 and busy=0.
REQ-037 SHALL, on reset asserted mid-frame, discard the remaining frame; no read data arriving after release is expected from the slave.

Structure
REQ-038 SHALL place the FSM state enum and the pixel-word field offsets in the shared package video_pkg.
REQ-039 SHALL instantiate one sub-module, fb_sc_fifo: a synchronous show-ahead FIFO with level output.

Verification (FRAME_W=4, FRAME_H=2, BURST_LEN=4, FIFO_DEPTH=8 unless noted)
REQ-040 Bench: start_frame, base 0x1000, no waitrequest, ready_in=1 -> bursts at 0x1000 and 0x1010 with burstcount 4; 8 pixels out; sop on pixel 0; eop on pixel 7; busy falls after eop.
REQ-041 Bench: ready_in=0 throughout -> at most 8 words outstanding plus buffered; avm_read held 0 once credit is exhausted; no overflow; first pixel stable until ready_in rises.
REQ-042 Bench: avm_waitrequest=1 for 5 cycles on the first burst -> avm_address/avm_burstcount unchanged for those cycles; single acceptance.
REQ-043 Bench: FRAME_W=3, FRAME_H=2 -> bursts of 4 and 2 words; eop on pixel 5.
REQ-044 Bench: second start_frame mid-frame -> ignored; exactly 8 pixels out; one sop and one eop.
REQ-045 Bench: reset_n pulsed after 3 pixels, then a new start_frame -> outputs cleared immediately; new frame starts with sop at pixel index 0.
